// File: rtl/ra_pkg.sv
// Shared types and default sizing for the ra_nr1w_sdr register array.
// Optional feature macro: RA_WR_BYPASS_EN (write-to-read bypass).
package ra_pkg;

  typedef enum logic {
    INIT,
    READY
  } ra_init_state_t;

  localparam int RA_WIDTH_DFLT    = 32;
  localparam int RA_DEPTH_DFLT    = 32;
  localparam int RA_RD_PORTS_DFLT = 2;

endpackage

// File: rtl/ra_init_seq.sv
// Post-reset clear sweep: walks every entry once, writing zero,
// then parks in READY until the next reset.
module ra_init_seq
  import ra_pkg::*;
#(
  parameter int DEPTH = RA_DEPTH_DFLT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] sweep_adr,
  output logic          sweep_we,
  output logic          init_busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ra_init_state_t state, state_nxt;
  logic [AW-1:0]  cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sweep_we  = 1'b0;
    init_busy = 1'b0;
    unique case (state)
      INIT: begin
        sweep_we  = 1'b1;
        init_busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: ;
    endcase
  end

  assign sweep_adr = cnt;

endmodule

// File: rtl/ra_nr1w_sdr.sv
// N-read / 1-write register array with registered read data.
// Define RA_WR_BYPASS_EN to forward same-cycle write data to readers.
module ra_nr1w_sdr
  import ra_pkg::*;
#(
  parameter int WIDTH    = RA_WIDTH_DFLT,
  parameter int DEPTH    = RA_DEPTH_DFLT,
  parameter int RD_PORTS = RA_RD_PORTS_DFLT,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic [RD_PORTS-1:0]       rd_enb,
  input  logic [RD_PORTS*AW-1:0]    rd_adr,
  output logic [RD_PORTS*WIDTH-1:0] rd_dat,
  input  logic                      wr_enb_0,
  input  logic [AW-1:0]             wr_adr_0,
  input  logic [WIDTH-1:0]          wr_dat_0,
  output logic                      init_busy,
  output logic                      adr_err
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]       sweep_adr;
  logic                sweep_we;
  logic                ready;
  logic                wr_ok;
  logic                wr_acc;
  logic                wr_bad;
  logic [RD_PORTS-1:0] rd_bad;

  ra_init_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_init (
    .clk      (clk),
    .reset    (reset),
    .sweep_adr(sweep_adr),
    .sweep_we (sweep_we),
    .init_busy(init_busy)
  );

  assign ready  = ~init_busy;
  assign wr_ok  = {1'b0, wr_adr_0} < DEPTH_W;
  assign wr_acc = ready & strobe & wr_enb_0 & wr_ok;
  assign wr_bad = ready & strobe & wr_enb_0 & ~wr_ok;

  // Array is cleared by the sweep, never by reset itself.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_adr] <= '0;
    end else if (wr_acc) begin
      mem[wr_adr_0] <= wr_dat_0;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]    adr;
    logic             ok;
    logic             acc;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;

    assign adr       = rd_adr[p*AW +: AW];
    assign ok        = {1'b0, adr} < DEPTH_W;
    assign acc       = ready & strobe & rd_enb[p];
    assign rd_bad[p] = acc & ~ok;

`ifdef RA_WR_BYPASS_EN
    assign data = (wr_acc && (wr_adr_0 == adr)) ? wr_dat_0 : mem[adr];
`else
    assign data = mem[adr];
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= '0;
      end else if (acc) begin
        q <= ok ? data : '0;
      end
    end

    assign rd_dat[p*WIDTH +: WIDTH] = q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adr_err <= 1'b0;
    end else begin
      adr_err <= wr_bad | (|rd_bad);
    end
  end

endmodule

// File: tb/tb_ra_nr1w_sdr.sv
// Scoreboard bench for ra_nr1w_sdr (DEPTH=36, two read ports).
// Honors RA_WR_BYPASS_EN to pick the expected same-address behaviour.
module tb_ra_nr1w_sdr;

  localparam int W     = 32;
  localparam int DEPTH = 36;
  localparam int NP    = 2;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic         err;
    logic         busy;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              strobe;
  logic [NP-1:0]     rd_enb;
  logic [NP*AW-1:0]  rd_adr;
  logic [NP*W-1:0]   rd_dat;
  logic              wr_enb_0;
  logic [AW-1:0]     wr_adr_0;
  logic [W-1:0]      wr_dat_0;
  logic              init_busy;
  logic              adr_err;

  int checks   = 0;
  int failures = 0;

  exp_t         sb[$];
  logic [W-1:0] mm [DEPTH];
  logic [W-1:0] m_rd [NP];
  int           busy_left;

  always #5 clk = ~clk;

  ra_nr1w_sdr #(
    .WIDTH   (W),
    .DEPTH   (DEPTH),
    .RD_PORTS(NP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe),
    .rd_enb   (rd_enb),
    .rd_adr   (rd_adr),
    .rd_dat   (rd_dat),
    .wr_enb_0 (wr_enb_0),
    .wr_adr_0 (wr_adr_0),
    .wr_dat_0 (wr_dat_0),
    .init_busy(init_busy),
    .adr_err  (adr_err)
  );

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_dat0", rd_dat[0 +: W], e.rd0);
        chk("rd_dat1", rd_dat[W +: W], e.rd1);
        chk("adr_err", {31'b0, adr_err}, {31'b0, e.err});
        chk("init_busy", {31'b0, init_busy}, {31'b0, e.busy});
      end
    end
  end

  // Called at a negedge: drive one cycle of inputs and predict its result.
  task automatic step(input logic s, input logic [NP-1:0] re,
                      input int a0, input int a1, input logic we,
                      input int wa, input logic [W-1:0] wd);
    exp_t e;
    int   a [NP];
    logic err;
    strobe   = s;
    rd_enb   = re;
    rd_adr   = {AW'(a1), AW'(a0)};
    wr_enb_0 = we;
    wr_adr_0 = AW'(wa);
    wr_dat_0 = wd;
    a[0] = a0;
    a[1] = a1;
    err  = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (s && re[p]) begin
          if (a[p] >= DEPTH) begin
            m_rd[p] = '0;
            err     = 1'b1;
          end else begin
            m_rd[p] = mm[a[p]];
`ifdef RA_WR_BYPASS_EN
            if (we && wa == a[p]) m_rd[p] = wd;
`endif
          end
        end
      end
      if (s && we) begin
        if (wa < DEPTH) mm[wa] = wd;
        else err = 1'b1;
      end
    end
    e.rd0  = m_rd[0];
    e.rd1  = m_rd[1];
    e.err  = err;
    e.busy = busy_left > 0;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 0, 0, 1'b0, 0, '0);
  endtask

  // Called at a negedge: pulse reset for one cycle, release at a negedge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_rd_dat0", rd_dat[0 +: W], '0);
    chk("rst_rd_dat1", rd_dat[W +: W], '0);
    chk("rst_adr_err", {31'b0, adr_err}, '0);
    chk("rst_init_busy", {31'b0, init_busy}, 32'd1);
    @(negedge clk);
    reset     = 1'b1;
    busy_left = DEPTH;
    for (int p = 0; p < NP; p++) m_rd[p] = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
  endtask

  initial begin
    reset    = 1'b0;
    strobe   = 1'b0;
    rd_enb   = '0;
    rd_adr   = '0;
    wr_enb_0 = 1'b0;
    wr_adr_0 = '0;
    wr_dat_0 = '0;
    @(negedge clk);
    do_reset();

    // Sweep with traffic that must be ignored, then first read.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 2'b11, i, 40, 1'b1, i, 32'hFFFF_0000 | i);
    step(1'b1, 2'b01, 5, 0, 1'b0, 0, '0);

    step(1'b1, 2'b00, 0, 0, 1'b1, 1, 32'h0000_AAAA);
    step(1'b1, 2'b11, 1, 1, 1'b0, 0, '0);
    step(1'b1, 2'b01, 8, 0, 1'b1, 8, 32'h0000_0008);
    step(1'b1, 2'b01, 1, 0, 1'b0, 0, '0);
    step(1'b0, 2'b11, 8, 8, 1'b1, 1, 32'hDEAD_BEEF);
    step(1'b1, 2'b10, 0, 1, 1'b0, 0, '0);
    step(1'b1, 2'b00, 0, 0, 1'b1, 40, 32'h0000_1234);
    step(1'b1, 2'b01, 40, 0, 1'b0, 0, '0);
    step(1'b1, 2'b11, 63, 35, 1'b1, 35, 32'h5A5A_5A5A);
    step(1'b1, 2'b11, 35, 35, 1'b1, 35, 32'hC3C3_C3C3);
    idle(2);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) != 0, NP'($urandom),
           $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom);

    do_reset();
    idle(10);
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 2'b11, 0, 0, 1'b1, i, 32'hBAD0_0000 | i);
    for (int i = 0; i < DEPTH; i += 2)
      step(1'b1, 2'b11, i, i + 1, 1'b0, 0, '0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ra_nr1w_sdr.md
RA_NR1W_SDR -- requirements
Module: ra_nr1w_sdr

Interface
REQ-001 Parameter WIDTH, default 32, data bits per entry.
REQ-002 Parameter DEPTH, default 32, number of entries; AW = $clog2(DEPTH).
REQ-003 Parameter RD_PORTS, default 2, number of independent read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 strobe  input  1  global access qualifier; reads and writes take effect only when high.
REQ-007 rd_enb  input  RD_PORTS  per-port read enable.
REQ-008 rd_adr  input  RD_PORTS*AW  per-port read address; port p occupies bits [p*AW +: AW].
REQ-009 rd_dat  output  RD_PORTS*WIDTH  per-port registered read data; port p occupies bits [p*WIDTH +: WIDTH].
REQ-010 wr_enb_0  input  1  write enable.
REQ-011 wr_adr_0  input  AW  write address.
REQ-012 wr_dat_0  input  WIDTH  write data.
REQ-013 init_busy  output  1  high while post-reset clear sweep runs.
REQ-014 adr_err  output  1  one-cycle pulse on any accepted access with address >= DEPTH.

Function
REQ-015 Init FSM states: INIT, READY; reset forces INIT with sweep counter 0.
REQ-016 In INIT, one entry per cycle is written to zero, counter 0..DEPTH-1; after entry DEPTH-1, next state READY; init_busy high exactly DEPTH cycles after reset release.
REQ-017 In INIT, rd_enb/wr_enb_0 are ignored, rd_dat holds 0, adr_err stays 0.
REQ-018 Write accepted in READY when wr_enb_0 & strobe & (wr_adr_0 < DEPTH); entry updated at that edge.
REQ-019 Read accepted on port p in READY when rd_enb[p] & strobe; rd_dat port p updates at that edge (latency 1) with entry contents.
REQ-020 Port p not accepted in a cycle: rd_dat port p holds its previous value.
REQ-021 Read address >= DEPTH: rd_dat port p loads 0; array unchanged.
REQ-022 Write address >= DEPTH: write dropped.
REQ-023 adr_err = registered OR of all accepted out-of-range reads/writes of previous cycle.
REQ-024 Multiple read ports on same address in same cycle return identical data.
REQ-025 Same-cycle accepted write and read to same address: behaviour per REQ-030/031.

Reset
REQ-026 Reset assertion asynchronously clears rd_dat to 0, adr_err to 0, init_busy to 1, FSM to INIT.
REQ-027 Array contents are not reset directly; they are cleared by the INIT sweep.
REQ-028 Reset asserted mid-sweep restarts sweep from entry 0 after release.
REQ-029 Reset asserted mid-operation in READY discards any in-flight write of that cycle.

Configuration
REQ-030 Macro RA_WR_BYPASS_EN defined: same-address read returns wr_dat_0 of the concurrent write.
REQ-031 Macro RA_WR_BYPASS_EN undefined: same-address read returns the pre-write contents.

Structure
REQ-032 Package ra_pkg holds enum ra_init_state_t {INIT, READY} and default constants RA_WIDTH_DFLT=32, RA_DEPTH_DFLT=32, RA_RD_PORTS_DFLT=2.
REQ-033 Sub-module ra_init_seq contains the init FSM and sweep counter, outputs sweep address, sweep write enable, init_busy.
REQ-034 Read ports generated by a generate loop over RD_PORTS; no per-port copy of the array.

Verification
REQ-035 Reset release, DEPTH=32 -> init_busy high exactly 32 cycles; then read addr 5 on port 0 -> rd_dat port 0 = 0 one cycle later.
REQ-036 Write 0x0000AAAA to addr 1 with strobe=1; next cycle read addr 1 on ports 0 and 1 -> both = 0x0000AAAA one cycle later.
REQ-037 Addr 8 holds 0; same cycle write 0x00000008 to addr 8 and read addr 8 -> 0x00000008 with RA_WR_BYPASS_EN, 0x00000000 without.
REQ-038 Read addr 1 with strobe=0 after rd_dat port 0 = 0x0000AAAA -> rd_dat port 0 stays 0x0000AAAA; write with strobe=0 leaves entry unchanged.
REQ-039 DEPTH=36 (AW=6): write 0x1234 to addr 40 -> adr_err pulses one cycle, array unchanged; read addr 40 -> rd_dat = 0, adr_err pulses.
REQ-040 Reset asserted at sweep cycle 10, released -> init_busy high full 32 cycles again; entries 0..31 read 0.
